// File: rtl/seg7_scan_driver_if.sv
// Load-side bundle for the seven-segment scan driver.
// The data source is the master; it receives pending back from the driver.
interface seg7_scan_driver_if #(
   parameter int NUM_DIGITS = 4,
   parameter int BRIGHT_W   = 3
);
   logic [4*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blank_in;
   logic [BRIGHT_W-1:0]     brightness;
   logic                    load;
   logic                    pending;

   modport master (
      output digits_in, dp_in, blank_in, brightness, load,
      input  pending
   );

   modport slave (
      input  digits_in, dp_in, blank_in, brightness, load,
      output pending
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scanner with ghost-blank gap, PWM brightness and
// frame-synchronous double-buffered loading; all pin outputs registered.
module seg7_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int SLOT_CYCLES  = 262144,
   parameter int BLANK_CYCLES = 1024,
   parameter int BRIGHT_W     = 3
) (
   input  logic                  clk_100MHz,
   input  logic                  rst_n,
   seg7_scan_driver_if.slave     bus,
   output logic [NUM_DIGITS-1:0] anode_out,
   output logic [6:0]            seg_out,
   output logic                  dp_out,
   output logic                  frame_start
);

   localparam int TICK_W = $clog2(SLOT_CYCLES);
   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam int LEN_W  = TICK_W + BRIGHT_W + 2;
   localparam int WIN    = SLOT_CYCLES - BLANK_CYCLES;

   typedef enum logic [1:0] {S_BLANK, S_ON, S_DIM} state_e;

   logic [TICK_W-1:0]       tick_q;
   logic [IDX_W-1:0]        index_q;
   state_e                  state_q, state_d;
   logic [4*NUM_DIGITS-1:0] stg_digits_q, shd_digits_q;
   logic [NUM_DIGITS-1:0]   stg_dp_q, shd_dp_q, stg_blank_q, shd_blank_q;
   logic [BRIGHT_W-1:0]     stg_bright_q, shd_bright_q;
   logic                    pending_q;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic [6:0]              seg_q, seg_d, seg_dec;
   logic                    dp_q, dp_d, fs_q, fs_d, lit_d;
   logic [3:0]              digit;
   logic                    tick_wrap, boundary;
   logic [LEN_W-1:0]        on_prod, on_len, on_end;

   assign tick_wrap = (tick_q == TICK_W'(SLOT_CYCLES - 1));
   assign boundary  = tick_wrap && (index_q == '0);

   // Lit window length scales with brightness; all-ones yields the whole post-blank window.
   assign on_prod = LEN_W'(WIN) * (LEN_W'(shd_bright_q) + LEN_W'(1));
   assign on_len  = on_prod >> BRIGHT_W;
   assign on_end  = LEN_W'(BLANK_CYCLES) + on_len;

   always_ff @(posedge clk_100MHz) begin
      if (!rst_n) begin
         tick_q  <= '0;
         index_q <= IDX_W'(NUM_DIGITS - 1);
      end else if (tick_wrap) begin
         tick_q  <= '0;
         index_q <= (index_q == '0) ? IDX_W'(NUM_DIGITS - 1) : index_q - 1'b1;
      end else begin
         tick_q  <= tick_q + 1'b1;
      end
   end

   // Staging absorbs loads; shadow only changes on the last cycle of a frame.
   always_ff @(posedge clk_100MHz) begin
      if (!rst_n) begin
         stg_digits_q <= '0;
         stg_dp_q     <= '0;
         stg_blank_q  <= '0;
         stg_bright_q <= '0;
         shd_digits_q <= '0;
         shd_dp_q     <= '0;
         shd_blank_q  <= '0;
         shd_bright_q <= '0;
         pending_q    <= 1'b0;
      end else if (boundary) begin
         if (bus.load) begin
            stg_digits_q <= bus.digits_in;
            stg_dp_q     <= bus.dp_in;
            stg_blank_q  <= bus.blank_in;
            stg_bright_q <= bus.brightness;
            shd_digits_q <= bus.digits_in;
            shd_dp_q     <= bus.dp_in;
            shd_blank_q  <= bus.blank_in;
            shd_bright_q <= bus.brightness;
         end else begin
            shd_digits_q <= stg_digits_q;
            shd_dp_q     <= stg_dp_q;
            shd_blank_q  <= stg_blank_q;
            shd_bright_q <= stg_bright_q;
         end
         pending_q <= 1'b0;
      end else if (bus.load) begin
         stg_digits_q <= bus.digits_in;
         stg_dp_q     <= bus.dp_in;
         stg_blank_q  <= bus.blank_in;
         stg_bright_q <= bus.brightness;
         pending_q    <= 1'b1;
      end
   end

   assign bus.pending = pending_q;

   always_ff @(posedge clk_100MHz) begin
      if (!rst_n) state_q <= S_BLANK;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (tick_wrap) begin
         state_d = S_BLANK;
      end else begin
         case (state_q)
            S_BLANK: if (tick_q == TICK_W'(BLANK_CYCLES - 1))
                        state_d = (on_len == '0) ? S_DIM : S_ON;
            S_ON:    if ((LEN_W'(tick_q) + LEN_W'(1)) == on_end)
                        state_d = S_DIM;
            default: state_d = state_q;
         endcase
      end
   end

   assign digit = shd_digits_q[{index_q, 2'b00} +: 4];

   always_comb begin
      case (digit)
         4'h0: seg_dec = 7'b0000001;
         4'h1: seg_dec = 7'b1001111;
         4'h2: seg_dec = 7'b0010010;
         4'h3: seg_dec = 7'b0000110;
         4'h4: seg_dec = 7'b1001100;
         4'h5: seg_dec = 7'b0100100;
         4'h6: seg_dec = 7'b0100000;
         4'h7: seg_dec = 7'b0001111;
         4'h8: seg_dec = 7'b0000000;
         4'h9: seg_dec = 7'b0000100;
         4'hA: seg_dec = 7'b0001000;
         4'hB: seg_dec = 7'b1100000;
         4'hC: seg_dec = 7'b0110001;
         4'hD: seg_dec = 7'b1000010;
         4'hE: seg_dec = 7'b0110000;
         default: seg_dec = 7'b0111000;
      endcase
   end

   always_comb begin
      lit_d = (state_q == S_ON) && !shd_blank_q[index_q];
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (lit_d) begin
         seg_d = seg_dec;
         dp_d  = ~shd_dp_q[index_q];
      end
      fs_d = (index_q == IDX_W'(NUM_DIGITS - 1)) && (tick_q == '0);
   end

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
      assign anode_d[gi] = ~(lit_d && (index_q == IDX_W'(gi)));
   end

   always_ff @(posedge clk_100MHz) begin
      if (!rst_n) begin
         anode_q <= '1;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         anode_q <= anode_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         fs_q    <= fs_d;
      end
   end

   assign anode_out   = anode_q;
   assign seg_out     = seg_q;
   assign dp_out      = dp_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: a frame-position model predicts every pin cycle of a 4-digit
// instance; an 8-digit instance is checked against the fixed scan pattern.
module tb_seg7_scan_driver;

   localparam int N     = 4;
   localparam int SLOT  = 16;
   localparam int BLANK = 2;
   localparam int BW    = 2;
   localparam int FRAME = N * SLOT;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst8_n = 1'b0;
   always #5 clk = ~clk;

   seg7_scan_driver_if #(.NUM_DIGITS(N), .BRIGHT_W(BW)) bus ();
   seg7_scan_driver_if #(.NUM_DIGITS(8), .BRIGHT_W(2))  bus8 ();

   logic [N-1:0] anode;
   logic [6:0]   seg;
   logic         dp, fs;
   logic [7:0]   anode8;
   logic [6:0]   seg8;
   logic         dp8, fs8;

   seg7_scan_driver #(.NUM_DIGITS(N), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK), .BRIGHT_W(BW)) u_dut (
      .clk_100MHz(clk), .rst_n(rst_n), .bus(bus),
      .anode_out(anode), .seg_out(seg), .dp_out(dp), .frame_start(fs)
   );

   seg7_scan_driver #(.NUM_DIGITS(8), .SLOT_CYCLES(8), .BLANK_CYCLES(1), .BRIGHT_W(2)) u_dut8 (
      .clk_100MHz(clk), .rst_n(rst8_n), .bus(bus8),
      .anode_out(anode8), .seg_out(seg8), .dp_out(dp8), .frame_start(fs8)
   );

   typedef struct {
      logic [N-1:0] an;
      logic [6:0]   seg;
      logic         dp;
      logic         fs;
      logic         pend;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

   // Reference state: position within the frame plus applied/staged display contents.
   int          pos_m = 0;
   logic [15:0] dig_app = '0, dig_stg = '0;
   logic [3:0]  dp_app = '0, dp_stg = '0, bl_app = '0, bl_stg = '0;
   logic [1:0]  br_app = '0, br_stg = '0;
   bit          pend_m = 1'b0;

   task automatic step(input bit rst, input bit ld, input logic [15:0] d,
                       input logic [3:0] dpv, input logic [3:0] bl, input logic [1:0] br);
      exp_t e;
      int   idx, t, on_len;
      bit   lit;
      @(negedge clk);
      rst_n          = ~rst;
      bus.load       = ld;
      bus.digits_in  = d;
      bus.dp_in      = dpv;
      bus.blank_in   = bl;
      bus.brightness = br;
      if (rst) begin
         e = '{an: '1, seg: 7'h7F, dp: 1'b1, fs: 1'b0, pend: 1'b0};
         pos_m = 0; pend_m = 1'b0;
         dig_app = '0; dig_stg = '0; dp_app = '0; dp_stg = '0;
         bl_app = '0; bl_stg = '0; br_app = '0; br_stg = '0;
      end else begin
         idx    = N - 1 - pos_m / SLOT;
         t      = pos_m % SLOT;
         on_len = ((SLOT - BLANK) * (int'(br_app) + 1)) / (1 << BW);
         lit    = (t >= BLANK) && (t < BLANK + on_len) && !bl_app[idx];
         e.an   = lit ? ~(4'b0001 << idx) : 4'hF;
         e.seg  = lit ? seg_tab[dig_app[idx*4 +: 4]] : 7'h7F;
         e.dp   = lit ? ~dp_app[idx] : 1'b1;
         e.fs   = (pos_m == 0);
         if (pos_m == FRAME - 1) begin
            if (ld) begin
               dig_app = d; dp_app = dpv; bl_app = bl; br_app = br;
               dig_stg = d; dp_stg = dpv; bl_stg = bl; br_stg = br;
            end else begin
               dig_app = dig_stg; dp_app = dp_stg; bl_app = bl_stg; br_app = br_stg;
            end
            pend_m = 1'b0;
         end else if (ld) begin
            dig_stg = d; dp_stg = dpv; bl_stg = bl; br_stg = br;
            pend_m = 1'b1;
         end
         e.pend = pend_m;
         pos_m  = (pos_m + 1) % FRAME;
      end
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 2'($urandom));
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] dpv,
                          input logic [3:0] bl, input logic [1:0] br);
      $display("load digits=%h dp=%b blank=%b bright=%0d at frame pos %0d", d, dpv, bl, br, pos_m);
      step(1'b0, 1'b1, d, dpv, bl, br);
   endtask

   task automatic do_reset(input int n);
      $display("reset for %0d cycles at frame pos %0d", n, pos_m);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, '0, '0);
   endtask

   // Monitor for the 4-digit instance: one scoreboard entry per clock.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (anode !== e.an || seg !== e.seg || dp !== e.dp || fs !== e.fs || bus.pending !== e.pend) begin
               miscompares++;
               $display("FAIL pins4 t=%0t anode=%b want %b seg=%b want %b dp=%b want %b fs=%b want %b pending=%b want %b",
                        $time, anode, e.an, seg, e.seg, dp, e.dp, fs, e.fs, bus.pending, e.pend);
            end
         end
      end
   end

   // 8-digit instance with cleared shadow: brightness 0 gives one lit cycle at tick 1 of each slot.
   initial begin
      int         n8, d8;
      logic [7:0] ea;
      logic       ef;
      n8 = 0;
      forever begin
         @(posedge clk);
         #3;
         if (rst8_n === 1'b0) begin
            n8 = 0;
            ea = 8'hFF;
            ef = 1'b0;
         end else begin
            d8 = n8 % 64;
            ea = (d8 % 8 == 1) ? ~(8'h01 << (7 - d8 / 8)) : 8'hFF;
            ef = (d8 == 0);
            n8++;
         end
         if (rst8_n === 1'b1 || n8 == 0) begin
            vectors++;
            if (anode8 !== ea || fs8 !== ef) begin
               miscompares++;
               $display("FAIL pins8 t=%0t anode=%b want %b fs=%b want %b", $time, anode8, ea, fs8, ef);
            end
         end
      end
   end

   initial begin
      bus.load = 1'b0; bus.digits_in = '0; bus.dp_in = '0; bus.blank_in = '0; bus.brightness = '0;
      bus8.load = 1'b0; bus8.digits_in = '0; bus8.dp_in = '0; bus8.blank_in = '0; bus8.brightness = '0;

      do_reset(3);
      rst8_n = 1'b1;
      idle(21);
      do_reset(3);
      idle(30);

      do_load(16'h12AF, 4'b0000, 4'b0000, 2'd3);
      idle(150);
      do_load(16'h0123, 4'b0000, 4'b0000, 2'd3); idle(FRAME + 10);
      do_load(16'h4567, 4'b0000, 4'b0000, 2'd3); idle(FRAME + 10);
      do_load(16'h89AB, 4'b0000, 4'b0000, 2'd3); idle(FRAME + 10);
      do_load(16'hCDEF, 4'b0000, 4'b0000, 2'd3); idle(FRAME + 10);

      do_load(16'h8888, 4'b0000, 4'b0000, 2'd0); idle(140);
      do_load(16'h8888, 4'b0000, 4'b0000, 2'd1); idle(140);
      do_load(16'h5A3C, 4'b0001, 4'b0100, 2'd3); idle(140);

      for (int i = 0; i < FRAME && pos_m != 10; i++) idle(1);
      do_load(16'h1111, 4'b1111, 4'b0000, 2'd2);
      idle(15);
      do_load(16'h2222, 4'b0000, 4'b0000, 2'd1);
      idle(10);
      do_load(16'h3333, 4'b1010, 4'b0000, 2'd3);
      for (int i = 0; i < FRAME && pos_m != FRAME - 1; i++) idle(1);
      do_load(16'hBEEF, 4'b0110, 4'b0000, 2'd2);
      idle(FRAME + 20);

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 299) == 0)
            do_reset(int'($urandom_range(1, 3)));
         else if ($urandom_range(0, 19) == 0)
            do_load(16'($urandom), 4'($urandom), 4'($urandom), 2'($urandom));
         else
            idle(1);
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #4;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain %0d entries left want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
